fifo_single_clk: RTL and testbench
==================================

Name: fifo_single_clk

Overview:
Synchronous single-clock FIFO buffer, 64 entries deep and 8 bits wide by default. It decouples a byte producer and a byte consumer within one clock domain. It provides registered read data, full and empty status flags, and an occupancy counter. It is a general-purpose buffering primitive for datapath blocks.

Parameters:
DATA_W, 8, width of each data word
DEPTH, 64, number of entries; must be a power of two, at least 2
CNT_W, 8, width of fifo_counter; must satisfy 2**CNT_W > DEPTH

Ports:
clk  input  1  system clock; all state changes on the rising edge
rst  input  1  synchronous reset, active-low; sampled on the rising edge of clk
wr_en  input  1  write request
rd_en  input  1  read request
buf_in  input  DATA_W  write data
buf_out  output  DATA_W  read data, registered
buf_empty  output  1  high when the occupancy is 0
buf_full  output  1  high when the occupancy equals DEPTH
fifo_counter  output  CNT_W  current occupancy, 0..DEPTH

Behaviour:
- Reset:
  - Asserted when rst=0 at a rising edge of clk.
  - Clears read pointer, write pointer, fifo_counter and buf_out to 0.
  - buf_empty=1, buf_full=0.
  - Memory contents are not cleared.
  - Reset overrides all other activity, including a reset asserted mid-operation.
- Pointers: rd_ptr and wr_ptr are log2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0.
- Flags: buf_empty = (fifo_counter==0) and buf_full = (fifo_counter==DEPTH). Both are combinational decodes of the registered counter, so they reflect the current state with no extra cycle of latency.
- Request qualification uses the state before the clock edge:
  - do_wr = wr_en & ~buf_full
  - do_rd = rd_en & ~buf_empty
- Write: when do_wr, mem[wr_ptr] <= buf_in and wr_ptr increments.
- Read: when do_rd, buf_out <= mem[rd_ptr] and rd_ptr increments.
  - Read latency is 1 cycle: data is valid after the edge on which rd_en was sampled.
  - When no read occurs, buf_out holds its last value.
- Counter update:
  - do_wr only: +1
  - do_rd only: -1
  - both or neither: unchanged
- Simultaneous request cases:
  - Read and write while neither empty nor full: both occur and the count is unchanged.
  - Both requested while empty: only the write occurs. buf_out does not see the new word that cycle, and there is no fall-through.
  - Both requested while full: only the read occurs and the write is dropped; the count goes to DEPTH-1.
- Overflow and underflow are silent:
  - A write while full is ignored; the pointer and counter do not change.
  - A read while empty is ignored; buf_out holds.
- Ordering: strict first-in first-out across pointer wrap-around.

Decomposition:
- Shared package fifo_pkg:
  - default constants FIFO_DATA_W=8, FIFO_DEPTH=64, FIFO_CNT_W=8
  - a pointer-width function (clog2)
- One natural sub-module, fifo_mem: a DEPTH x DATA_W synchronous-write array with a registered read port, driven by the qualified enables and the pointers.
- Pointer, counter and flag logic stay in fifo_single_clk.

Test Plan:
- Reset check: hold rst=0 for 2 cycles, then release. Required: fifo_counter=0, buf_empty=1, buf_full=0, buf_out=0.
- Fill: write 0x01..0x40 over 64 consecutive cycles. Required: fifo_counter steps 1..64, then buf_full=1 and buf_empty=0. A 65th write of 0xAA leaves the counter at 64.
- Drain: after the fill, assert rd_en for 64 cycles. Required: buf_out emits 0x01..0x40 in order, one cycle after each request. Then fifo_counter=0 and buf_empty=1. An extra read leaves buf_out=0x40.
- Simultaneous read and write at occupancy 10: run for 20 cycles. Required: the counter stays at 10 and the output sequence continues in order. Run this across pointer wrap-around (start with wr_ptr=60).
- Edge simultaneity:
  - Both requested while empty: counter becomes 1 and buf_out is unchanged.
  - Both requested while full: counter becomes 63, the oldest word is output, and the written word is not stored.
- Mid-operation reset: at occupancy 30, pull rst low for 1 cycle. Required: counter=0 and buf_empty=1. A subsequent write of 0x55 followed by a read returns 0x55.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared defaults and sizing helper for the single-clock FIFO.
package fifo_pkg;

    localparam int FIFO_DATA_W = 8;
    localparam int FIFO_DEPTH  = 64;
    localparam int FIFO_CNT_W  = 8;

    // Smallest w with 2**w >= depth, written as a bounded loop so it elaborates anywhere.
    function automatic int ptr_w(input int depth);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < depth) w = i + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x DATA_W storage: synchronous write, registered read that holds when idle.
module fifo_mem #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 64,
    parameter int AW     = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic              re,
    input  logic [AW-1:0]     waddr,
    input  logic [AW-1:0]     raddr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Array itself is never reset so it can map onto plain RAM.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (!rst)    rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/fifo_single_clk.sv
// Single-clock FIFO: pointers, occupancy counter and status flags around fifo_mem.
module fifo_single_clk
    import fifo_pkg::*;
#(
    parameter int DATA_W = FIFO_DATA_W,
    parameter int DEPTH  = FIFO_DEPTH,
    parameter int CNT_W  = FIFO_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [DATA_W-1:0] buf_in,
    output logic [DATA_W-1:0] buf_out,
    output logic              buf_empty,
    output logic              buf_full,
    output logic [CNT_W-1:0]  fifo_counter
);

    localparam int AW = ptr_w(DEPTH);

    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          do_wr, do_rd;

    assign buf_empty = (fifo_counter == '0);
    assign buf_full  = (fifo_counter == CNT_W'(DEPTH));

    // Gating with rst keeps a reset cycle from touching memory or the output register.
    assign do_wr = wr_en & ~buf_full  & rst;
    assign do_rd = rd_en & ~buf_empty & rst;

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_counter <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + AW'(1);
            if (do_rd) rd_ptr <= rd_ptr + AW'(1);
            case ({do_wr, do_rd})
                2'b10:   fifo_counter <= fifo_counter + CNT_W'(1);
                2'b01:   fifo_counter <= fifo_counter - CNT_W'(1);
                default: fifo_counter <= fifo_counter;
            endcase
        end
    end

    fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (do_wr),
        .re    (do_rd),
        .waddr (wr_ptr),
        .raddr (rd_ptr),
        .wdata (buf_in),
        .rdata (buf_out)
    );

endmodule

// File: tb/tb_fifo_single_clk.sv
// Directed bench for fifo_single_clk: fill/drain, wrap-around streaming, edge cases, mid-run reset.
module tb_fifo_single_clk;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en, rd_en;
    logic [7:0] buf_in;
    logic [7:0] buf_out;
    logic       buf_empty, buf_full;
    logic [7:0] fifo_counter;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fifo_single_clk dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .rd_en        (rd_en),
        .buf_in       (buf_in),
        .buf_out      (buf_out),
        .buf_empty    (buf_empty),
        .buf_full     (buf_full),
        .fifo_counter (fifo_counter)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock; inputs change and outputs are sampled 1ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic push(input logic [7:0] d);
        wr_en = 1'b1; rd_en = 1'b0; buf_in = d;
        tick();
        idle();
    endtask

    task automatic pop_expect(input string tag, input logic [7:0] d);
        wr_en = 1'b0; rd_en = 1'b1;
        tick();
        idle();
        chk(tag, 32'(buf_out), 32'(d));
    endtask

    initial begin
        rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0; buf_in = '0;

        // Reset held two cycles
        tick(); tick();
        rst = 1'b1;
        chk("rst_cnt",   32'(fifo_counter), 32'd0);
        chk("rst_empty", 32'(buf_empty),    32'd1);
        chk("rst_full",  32'(buf_full),     32'd0);
        chk("rst_out",   32'(buf_out),      32'd0);

        // Fill 0x01..0x40
        for (int i = 1; i <= 64; i++) begin
            wr_en = 1'b1; buf_in = 8'(i);
            tick();
            chk("fill_cnt", 32'(fifo_counter), 32'(i));
        end
        chk("fill_full",  32'(buf_full),  32'd1);
        chk("fill_empty", 32'(buf_empty), 32'd0);
        buf_in = 8'hAA;
        tick();
        idle();
        chk("ovf_cnt",  32'(fifo_counter), 32'd64);
        chk("ovf_full", 32'(buf_full),     32'd1);

        // Drain; 0xAA must not appear
        for (int i = 1; i <= 64; i++) pop_expect("drain_out", 8'(i));
        chk("drain_cnt",   32'(fifo_counter), 32'd0);
        chk("drain_empty", 32'(buf_empty),    32'd1);
        pop_expect("udf_hold", 8'h40);
        chk("udf_cnt", 32'(fifo_counter), 32'd0);

        // Position pointers: wr_ptr=60, rd_ptr=50, occupancy 10 holding 50..59
        for (int k = 0; k < 60; k++) push(8'(k));
        for (int k = 0; k < 50; k++) pop_expect("pre_out", 8'(k));
        chk("pre_cnt", 32'(fifo_counter), 32'd10);

        // Streaming across wrap: write 60..79, read 50..69
        for (int k = 0; k < 20; k++) begin
            wr_en = 1'b1; rd_en = 1'b1; buf_in = 8'(60 + k);
            tick();
            chk("sim_out", 32'(buf_out),      32'(50 + k));
            chk("sim_cnt", 32'(fifo_counter), 32'd10);
        end
        idle();
        for (int k = 70; k < 80; k++) pop_expect("post_out", 8'(k));
        chk("post_empty", 32'(buf_empty), 32'd1);

        // Both requested while empty: write only, output holds 0x4F
        wr_en = 1'b1; rd_en = 1'b1; buf_in = 8'h33;
        tick();
        idle();
        chk("emp_both_cnt", 32'(fifo_counter), 32'd1);
        chk("emp_both_out", 32'(buf_out),      32'h4F);
        pop_expect("emp_both_rd", 8'h33);
        chk("emp_both_cnt2", 32'(fifo_counter), 32'd0);

        // Both requested while full: read only, 0xEE dropped
        for (int k = 0; k < 64; k++) push(8'(8'h80 + k));
        chk("full2_full", 32'(buf_full), 32'd1);
        wr_en = 1'b1; rd_en = 1'b1; buf_in = 8'hEE;
        tick();
        idle();
        chk("full_both_cnt",  32'(fifo_counter), 32'd63);
        chk("full_both_out",  32'(buf_out),      32'h80);
        chk("full_both_full", 32'(buf_full),     32'd0);
        for (int k = 1; k < 64; k++) pop_expect("full_drain", 8'(8'h80 + k));
        chk("full_drain_cnt", 32'(fifo_counter), 32'd0);
        pop_expect("full_no_ee", 8'hBF);

        // Mid-operation reset at occupancy 30
        for (int k = 0; k < 30; k++) push(8'(k + 1));
        chk("mid_cnt", 32'(fifo_counter), 32'd30);
        rst = 1'b0; wr_en = 1'b1; rd_en = 1'b1; buf_in = 8'h77;
        tick();
        rst = 1'b1;
        idle();
        chk("mid_rst_cnt",   32'(fifo_counter), 32'd0);
        chk("mid_rst_empty", 32'(buf_empty),    32'd1);
        chk("mid_rst_out",   32'(buf_out),      32'd0);
        push(8'h55);
        chk("mid_wr_cnt", 32'(fifo_counter), 32'd1);
        pop_expect("mid_rd", 8'h55);
        chk("mid_rd_empty", 32'(buf_empty), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
